// File: rtl/nios_system_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32 multiplier among NUM_REQ requesters.
// Optional grant/stall counters are built in when NIOS_MULT_ARB_STATS_EN is defined.
module nios_system_mult_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int MUL_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [32*NUM_REQ-1:0]  req_src1,
   input  logic [32*NUM_REQ-1:0]  req_src2,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [31:0]            rsp_result,
   output logic [31:0]            mul_src1,
   output logic [31:0]            mul_src2,
   input  logic [31:0]            mul_result
`ifdef NIOS_MULT_ARB_STATS_EN
   ,
   input  logic                   stat_clr,
   output logic [16*NUM_REQ-1:0]  stat_grant_cnt,
   output logic [15:0]            stat_stall_cnt
`endif
);

   logic [1:0] r_rr_ptr;
   logic [1:0] w_grant_id;
   logic       w_grant_found;
   logic       w_xfer;
   logic       w_last_vld;

   logic       r_tag_vld [MUL_LATENCY];
   logic [1:0] r_tag_id  [MUL_LATENCY];

   // Visit positions rr_ptr, rr_ptr+1, ... (with wrap); first valid requester wins.
   always_comb begin
      w_grant_id    = '0;
      w_grant_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_grant_found && req_valid[i] && (((int'(r_rr_ptr) + k) % NUM_REQ) == i)) begin
               w_grant_found = 1'b1;
               w_grant_id    = 2'(i);
            end
         end
      end
   end

   assign w_xfer = w_grant_found & reset_n & ~flush;

   always_comb begin
      req_ready = '0;
      mul_src1  = '0;
      mul_src2  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_xfer && (w_grant_id == 2'(i))) begin
            req_ready[i] = 1'b1;
            mul_src1     = req_src1[32*i +: 32];
            mul_src2     = req_src2[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rr_ptr <= '0;
      end else if (w_xfer) begin
         r_rr_ptr <= (w_grant_id == 2'(NUM_REQ-1)) ? 2'd0 : w_grant_id + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_tag_vld[0] <= 1'b0;
         r_tag_id[0]  <= '0;
      end else begin
         r_tag_vld[0] <= w_xfer;
         r_tag_id[0]  <= w_grant_id;
      end
   end

   for (genvar gi = 1; gi < MUL_LATENCY; gi++) begin : g_tag
      always_ff @(posedge clk) begin
         if (!reset_n || flush) begin
            r_tag_vld[gi] <= 1'b0;
            r_tag_id[gi]  <= '0;
         end else begin
            r_tag_vld[gi] <= r_tag_vld[gi-1];
            r_tag_id[gi]  <= r_tag_id[gi-1];
         end
      end
   end

   // A result landing in a flush or reset cycle belongs to a discarded operation.
   assign w_last_vld = r_tag_vld[MUL_LATENCY-1] & reset_n & ~flush;

   always_comb begin
      rsp_valid  = '0;
      rsp_result = w_last_vld ? mul_result : 32'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = w_last_vld && (r_tag_id[MUL_LATENCY-1] == 2'(i));
      end
   end

`ifdef NIOS_MULT_ARB_STATS_EN
   logic [15:0] r_grant_cnt [NUM_REQ];
   logic [15:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = |(req_valid & ~req_ready);

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
      always_ff @(posedge clk) begin
         if (!reset_n || stat_clr) begin
            r_grant_cnt[gi] <= '0;
         end else if (req_ready[gi] && (r_grant_cnt[gi] != 16'hFFFF)) begin
            r_grant_cnt[gi] <= r_grant_cnt[gi] + 16'd1;
         end
      end
      assign stat_grant_cnt[16*gi +: 16] = r_grant_cnt[gi];
   end

   always_ff @(posedge clk) begin
      if (!reset_n || stat_clr) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_nios_system_mult_arbiter.sv
// Randomized self-checking bench for nios_system_mult_arbiter against a queue-based
// model of issued operations and their due cycles.
module tb_nios_system_mult_arbiter;

   localparam int N = 3;
   localparam int L = 3;

   logic            clk = 1'b0;
   logic            reset_n, flush;
   logic [N-1:0]    req_valid, req_ready, rsp_valid;
   logic [32*N-1:0] req_src1, req_src2;
   logic [31:0]     rsp_result, mul_src1, mul_src2, mul_result;
   logic [31:0]     src_a [N];
   logic [31:0]     src_b [N];
   logic [31:0]     cell_pipe [L];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign req_src1[32*gi +: 32] = src_a[gi];
      assign req_src2[32*gi +: 32] = src_b[gi];
   end

   // Multiplier cell: L registers from operands to product.
   always @(posedge clk) begin
      cell_pipe[0] <= mul_src1 * mul_src2;
      for (int k = 1; k < L; k++) cell_pipe[k] <= cell_pipe[k-1];
   end
   assign mul_result = cell_pipe[L-1];

   nios_system_mult_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src1(req_src1), .req_src2(req_src2),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result)
   );

   typedef struct {
      int          due;
      int          id;
      logic [31:0] prod;
   } pend_t;

   pend_t       q[$];
   int          ptr_m, now, last_grant, exp_grant;
   int          tests_run = 0, tests_failed = 0;
   logic [N-1:0] exp_ready, exp_rsp_valid;
   logic [31:0]  exp_rsp_result, exp_src1, exp_src2;

   function automatic logic [31:0] rand_op();
      case ($urandom_range(7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   // Expected outputs for the current cycle from the model state and current inputs.
   task automatic compute_expect();
      exp_grant = -1;
      if (reset_n && !flush) begin
         for (int k = 0; k < N; k++) begin
            if (exp_grant < 0 && req_valid[(ptr_m + k) % N]) exp_grant = (ptr_m + k) % N;
         end
      end
      exp_ready = '0; exp_src1 = '0; exp_src2 = '0;
      if (exp_grant >= 0) begin
         exp_ready[exp_grant] = 1'b1;
         exp_src1 = src_a[exp_grant];
         exp_src2 = src_b[exp_grant];
      end
      exp_rsp_valid = '0; exp_rsp_result = '0;
      if (reset_n && !flush && q.size() > 0 && q[0].due == now) begin
         exp_rsp_valid[q[0].id] = 1'b1;
         exp_rsp_result = q[0].prod;
      end
   endtask

   // Advance one clock: update the model at the edge, return at the next negedge.
   task automatic tick();
      pend_t       p;
      logic [63:0] full;
      compute_expect();
      @(posedge clk);
      last_grant = exp_grant;
      if (q.size() > 0 && q[0].due == now) void'(q.pop_front());
      if (!reset_n) begin
         q.delete();
         ptr_m = 0;
      end else if (flush) begin
         q.delete();
      end else if (exp_grant >= 0) begin
         full   = {32'd0, src_a[exp_grant]} * {32'd0, src_b[exp_grant]};
         p.due  = now + L;
         p.id   = exp_grant;
         p.prod = full[31:0];
         q.push_back(p);
         ptr_m = (exp_grant + 1) % N;
      end
      now++;
      @(negedge clk);
   endtask

   // Requesters hold until accepted; grantee and idle ones may start a new request.
   task automatic pick_next(input int p_new);
      for (int i = 0; i < N; i++) begin
         if (!req_valid[i] || last_grant == i) begin
            req_valid[i] = ($urandom_range(99) < p_new);
            src_a[i] = rand_op();
            src_b[i] = rand_op();
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req_valid = N'($urandom);
         #1; compute_expect();
         tests_run++;
         if ({req_ready, rsp_valid, rsp_result, mul_src1, mul_src2} !== {N'(0), N'(0), 96'd0}) begin
            tests_failed++;
            $display("FAIL reset cyc=%0d rdy=%b rsp=%b res=%h src=%h*%h required all zero",
                     now, req_ready, rsp_valid, rsp_result, mul_src1, mul_src2);
         end
         tick();
      end
      req_valid = '0;
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      logic [31:0] got[$];
      for (int c = 0; c < L + 4; c++) begin
         req_valid = (c < 2) ? N'(1) : N'(0);
         src_a[0] = (c == 0) ? 32'd3 : 32'd7;
         src_b[0] = (c == 0) ? 32'd5 : 32'd9;
         #1; compute_expect();
         if (rsp_valid[0]) got.push_back(rsp_result);
         tests_run++;
         if ({req_ready, rsp_valid, rsp_result, mul_src1, mul_src2} !== {exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2}) begin
            tests_failed++;
            $display("FAIL single cyc=%0d got rdy=%b rsp=%b res=%h src=%h*%h exp rdy=%b rsp=%b res=%h src=%h*%h",
                     now, req_ready, rsp_valid, rsp_result, mul_src1, mul_src2, exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2);
         end
         tick();
      end
      tests_run++;
      if (got.size() != 2 || got[0] !== 32'd15 || got[1] !== 32'd63) begin
         tests_failed++;
         $display("FAIL single_results got %0d results (first %0d) required 2 results 15,63",
                  got.size(), (got.size() > 0) ? got[0] : 0);
      end
   endtask

   task automatic test_contention();
      int prev = -1;
      int g_obs;
      req_valid = '1;
      for (int i = 0; i < N; i++) begin src_a[i] = rand_op(); src_b[i] = rand_op(); end
      for (int c = 0; c < 4 * N + L + 2; c++) begin
         if (c >= 4 * N) req_valid = '0;
         #1; compute_expect();
         g_obs = -1;
         for (int i = 0; i < N; i++) if (req_ready[i]) g_obs = i;
         tests_run++;
         if ({req_ready, rsp_valid, rsp_result, mul_src1, mul_src2} !== {exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2}) begin
            tests_failed++;
            $display("FAIL contention cyc=%0d got rdy=%b rsp=%b res=%h src=%h*%h exp rdy=%b rsp=%b res=%h src=%h*%h",
                     now, req_ready, rsp_valid, rsp_result, mul_src1, mul_src2, exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2);
         end
         if (c < 4 * N) begin
            tests_run++;
            if (prev >= 0 && g_obs != (prev + 1) % N) begin
               tests_failed++;
               $display("FAIL contention_rotate cyc=%0d grant=%0d required %0d", now, g_obs, (prev + 1) % N);
            end
            prev = g_obs;
         end
         tick();
         if (last_grant >= 0) begin src_a[last_grant] = rand_op(); src_b[last_grant] = rand_op(); end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] got[$];
      for (int c = 0; c < L + 4; c++) begin
         req_valid = (c < 2) ? N'(2) : N'(0);
         src_a[1] = (c == 0) ? 32'hFFFF_FFFF : 32'h0001_0000;
         src_b[1] = (c == 0) ? 32'h0000_0002 : 32'h0001_0000;
         #1; compute_expect();
         if (rsp_valid[1]) got.push_back(rsp_result);
         tests_run++;
         if ({req_ready, rsp_valid, rsp_result, mul_src1, mul_src2} !== {exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2}) begin
            tests_failed++;
            $display("FAIL overflow cyc=%0d got rdy=%b rsp=%b res=%h src=%h*%h exp rdy=%b rsp=%b res=%h src=%h*%h",
                     now, req_ready, rsp_valid, rsp_result, mul_src1, mul_src2, exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2);
         end
         tick();
      end
      tests_run++;
      if (got.size() != 2 || got[0] !== 32'hFFFF_FFFE || got[1] !== 32'd0) begin
         tests_failed++;
         $display("FAIL overflow_results got %0d results (first %h) required FFFFFFFE then 00000000",
                  got.size(), (got.size() > 0) ? got[0] : 32'd0);
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      for (int c = 0; c < 3 * L + 2; c++) begin
         req_valid = (c < 2 * L) ? N'(4) : N'(0);
         src_a[2] = rand_op(); src_b[2] = rand_op();
         #1; compute_expect();
         if (rsp_valid[2]) pulses++;
         tests_run++;
         if ({req_ready, rsp_valid, rsp_result, mul_src1, mul_src2} !== {exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2}) begin
            tests_failed++;
            $display("FAIL back_to_back cyc=%0d got rdy=%b rsp=%b res=%h src=%h*%h exp rdy=%b rsp=%b res=%h src=%h*%h",
                     now, req_ready, rsp_valid, rsp_result, mul_src1, mul_src2, exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2);
         end
         tick();
      end
      tests_run++;
      if (pulses != 2 * L) begin
         tests_failed++;
         $display("FAIL back_to_back_count pulses=%0d required %0d", pulses, 2 * L);
      end
   endtask

   task automatic test_flush();
      int pulses = 0;
      int first_rsp = -1;
      int issue_cyc = -1;
      for (int c = 0; c < L + 7; c++) begin
         req_valid = (c < 4) ? N'(1) : N'(0);
         flush = (c == 2);
         if (c < 3) begin src_a[0] = 32'(c + 2); src_b[0] = 32'(c + 11); end
         #1; compute_expect();
         if (c == 2) begin
            tests_run++;
            if (req_ready !== N'(0)) begin
               tests_failed++;
               $display("FAIL flush_ready cyc=%0d rdy=%b required 0", now, req_ready);
            end
         end
         if (c == 3 && req_ready[0]) issue_cyc = now;
         if (c >= 3 && rsp_valid[0]) begin
            pulses++;
            if (first_rsp < 0) first_rsp = now;
         end
         tests_run++;
         if ({req_ready, rsp_valid, rsp_result, mul_src1, mul_src2} !== {exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2}) begin
            tests_failed++;
            $display("FAIL flush cyc=%0d got rdy=%b rsp=%b res=%h src=%h*%h exp rdy=%b rsp=%b res=%h src=%h*%h",
                     now, req_ready, rsp_valid, rsp_result, mul_src1, mul_src2, exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2);
         end
         tick();
      end
      flush = 1'b0;
      tests_run++;
      if (issue_cyc < 0 || pulses != 1 || first_rsp != issue_cyc + L) begin
         tests_failed++;
         $display("FAIL flush_after pulses=%0d rsp_cyc=%0d issue_cyc=%0d required 1 pulse at issue+%0d",
                  pulses, first_rsp, issue_cyc, L);
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      for (int c = 0; c < L + 6; c++) begin
         reset_n = !(c == 0 || c == 3);
         case (c)
            1:       req_valid = N'(2);
            4:       req_valid = N'(3);
            default: req_valid = N'(0);
         endcase
         src_a[1] = 32'd6; src_b[1] = 32'd7;
         src_a[0] = 32'd4; src_b[0] = 32'd5;
         #1; compute_expect();
         if (c >= 2 && c <= 4 && rsp_valid != N'(0)) pulses++;
         if (c == 4) begin
            tests_run++;
            if (req_ready !== N'(1)) begin
               tests_failed++;
               $display("FAIL reset_mid_grant cyc=%0d rdy=%b required %b", now, req_ready, N'(1));
            end
         end
         tests_run++;
         if ({req_ready, rsp_valid, rsp_result, mul_src1, mul_src2} !== {exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2}) begin
            tests_failed++;
            $display("FAIL reset_mid cyc=%0d got rdy=%b rsp=%b res=%h src=%h*%h exp rdy=%b rsp=%b res=%h src=%h*%h",
                     now, req_ready, rsp_valid, rsp_result, mul_src1, mul_src2, exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2);
         end
         tick();
      end
      reset_n = 1'b1;
      tests_run++;
      if (pulses != 0) begin
         tests_failed++;
         $display("FAIL reset_mid_rsp pulses=%0d required 0", pulses);
      end
   endtask

   task automatic test_random();
      req_valid = '0;
      for (int c = 0; c < 400; c++) begin
         if (c < 380) begin
            flush   = ($urandom_range(99) < 6);
            reset_n = !($urandom_range(99) < 2);
         end else begin
            flush = 1'b0; reset_n = 1'b1; req_valid = '0;
         end
         #1; compute_expect();
         tests_run++;
         if ({req_ready, rsp_valid, rsp_result, mul_src1, mul_src2} !== {exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2}) begin
            tests_failed++;
            $display("FAIL random cyc=%0d got rdy=%b rsp=%b res=%h src=%h*%h exp rdy=%b rsp=%b res=%h src=%h*%h",
                     now, req_ready, rsp_valid, rsp_result, mul_src1, mul_src2, exp_ready, exp_rsp_valid, exp_rsp_result, exp_src1, exp_src2);
         end
         tick();
         if (c < 379) pick_next(60);
      end
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; req_valid = '0;
      for (int i = 0; i < N; i++) begin src_a[i] = '0; src_b[i] = '0; end
      ptr_m = 0; now = 0; last_grant = -1;
      @(negedge clk);
      test_reset();
      test_single();
      test_contention();
      test_overflow();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
